// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Transmit half of a UART. Pulls bytes from a fifo read port and serializes
//   each one as: start bit (0), DLEN data bits LSB first, an optional parity
//   bit, then STOP_BITS stop bits (1). Bit timing comes from an internal
//   counter on clk; there is no external baud enable.
//
// Parameters
//   DLEN          data bits per frame (matches the fifo word width)
//   CLKS_PER_BIT  clk cycles per serial bit, >= 2
//   PARITY_EN     1 = append a parity bit after the data bits
//   PARITY_ODD    0 = even parity, 1 = odd parity
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   i_en           1 = allowed to start new frames
//   i_fifo_rempty  fifo empty flag
//   o_fifo_ren     fifo read strobe, one-cycle pulse
//   i_fifo_rdata   fifo read data, valid the cycle after o_fifo_ren
//   o_tx           serial line, idles high, registered
//   o_busy         high from FETCH through the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DLEN         = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_en,
  input  logic            i_fifo_rempty,
  output logic            o_fifo_ren,
  input  logic [DLEN-1:0] i_fifo_rdata,
  output logic            o_tx,
  output logic            o_busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DLEN > 1) ? $clog2(DLEN) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DLEN - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DLEN-1:0]       shreg;
  logic                  par_bit;

  // Parity over the data word; odd parity inverts the even result.
  function automatic logic parity_of(input logic [DLEN-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  logic bit_end;
  logic can_start;

  // Last clk cycle of the current serial bit.
  assign bit_end   = (baud_cnt == BAUD_LAST);
  // The only two points where a new frame may be requested from the fifo.
  assign can_start = i_en && !i_fifo_rempty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      o_tx       <= 1'b1;
      o_fifo_ren <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_fifo_ren <= 1'b0;

      case (state)
        IDLE: begin
          o_tx     <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (can_start) begin
            state      <= FETCH;
            o_fifo_ren <= 1'b1;
            o_busy     <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end

        // Read strobe is out this cycle; data arrives during LOAD.
        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shreg    <= i_fifo_rdata;
          par_bit  <= (PARITY_EN != 0) ? parity_of(i_fifo_rdata) : 1'b0;
          o_tx     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= START;
        end

        // Entering DATA drives bit 0 and pre-shifts, so shreg[0] always
        // holds the next bit to send.
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                o_tx  <= par_bit;
                state <= PARITY;
              end else begin
                o_tx  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // bit_idx is reused here to count stop bits.
        STOP: begin
          o_tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (can_start) begin
                state      <= FETCH;
                o_fifo_ren <= 1'b1;
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          o_tx     <= 1'b1;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx with CLKS_PER_BIT=4, DLEN=8. Four instances
//   cover the parameter variants: lane 0 plain 8N1, lane 1 even parity,
//   lane 2 odd parity, lane 3 two stop bits. Each lane has its own small
//   fifo model. Expected frames are hand-computed bit patterns, where bit k
//   of the pattern is the k-th serial bit on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk;
  logic       rstn;
  logic [3:0] en;
  logic [3:0] rempty;
  wire  [3:0] ren;
  wire  [3:0] tx;
  wire  [3:0] busy;
  logic [7:0] rdata [4];

  logic [7:0] mem [4][16];
  int         wp [4] = '{default: 0};
  int         rp [4] = '{default: 0};
  int         underflow [4] = '{default: 0};

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.DLEN(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .i_en(en[0]), .i_fifo_rempty(rempty[0]),
    .o_fifo_ren(ren[0]), .i_fifo_rdata(rdata[0]), .o_tx(tx[0]), .o_busy(busy[0]));

  uart_tx #(.DLEN(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rstn(rstn), .i_en(en[1]), .i_fifo_rempty(rempty[1]),
    .o_fifo_ren(ren[1]), .i_fifo_rdata(rdata[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  uart_tx #(.DLEN(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rstn(rstn), .i_en(en[2]), .i_fifo_rempty(rempty[2]),
    .o_fifo_ren(ren[2]), .i_fifo_rdata(rdata[2]), .o_tx(tx[2]), .o_busy(busy[2]));

  uart_tx #(.DLEN(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rstn(rstn), .i_en(en[3]), .i_fifo_rempty(rempty[3]),
    .o_fifo_ren(ren[3]), .i_fifo_rdata(rdata[3]), .o_tx(tx[3]), .o_busy(busy[3]));

  // Fifo models: data appears the cycle after a read strobe.
  always_comb begin
    for (int k = 0; k < 4; k++) rempty[k] = (rp[k] == wp[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ren[k]) begin
        if (rp[k] == wp[k]) underflow[k] <= underflow[k] + 1;
        rdata[k] <= mem[k][rp[k]];
        rp[k]    <= rp[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] d);
    mem[lane][wp[lane]] = d;
    wp[lane] = wp[lane] + 1;
  endtask

  // Called on the FETCH-cycle sample point; returns on the first START sample.
  task automatic fetch_seq(input int lane, input string tag);
    chk({tag, "_ren"}, ren[lane], 1);
    chk({tag, "_busy"}, busy[lane], 1);
    chk({tag, "_tx_fetch"}, tx[lane], 1);
    @(negedge clk);
    chk({tag, "_ren_load"}, ren[lane], 0);
    chk({tag, "_tx_load"}, tx[lane], 1);
    @(negedge clk);
  endtask

  task automatic check_frame(input int lane, input logic [15:0] bits, input int nbits,
                             input string tag);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_tx"}, tx[lane], bits[b]);
        chk({tag, "_busy"}, busy[lane], 1);
        chk({tag, "_ren"}, ren[lane], 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle_check(input int lane, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tx"}, tx[lane], 1);
      chk({tag, "_busy"}, busy[lane], 0);
      chk({tag, "_ren"}, ren[lane], 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rstn = 1'b0;
    en   = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_ren", ren, 4'h0);
    rstn = 1'b1;
    en   = 4'b1111;
    @(negedge clk);
    idle_check(0, 2, "idle_empty");

    // Single 0xA5 frame, no parity
    push(0, 8'hA5);
    @(negedge clk);
    fetch_seq(0, "a5");
    check_frame(0, 16'h034A, 10, "a5");
    idle_check(0, 3, "a5_after");
    chk("a5_reads", rp[0], 1);

    // Back-to-back 0x00 then 0xFF: two idle-high cycles between frames
    push(0, 8'h00);
    push(0, 8'hFF);
    @(negedge clk);
    fetch_seq(0, "b2b0");
    check_frame(0, 16'h0200, 10, "b2b0");
    fetch_seq(0, "b2b1");
    check_frame(0, 16'h03FE, 10, "b2b1");
    idle_check(0, 4, "b2b_after");
    chk("b2b_reads", rp[0], 3);

    // Reset mid-DATA (bit 3 of 0xA5, which is a 0 on the line)
    push(0, 8'hA5);
    @(negedge clk);
    fetch_seq(0, "rst");
    check_frame(0, 16'h034A, 4, "rst_pre");
    chk("rst_bit3_a", tx[0], 0);
    @(negedge clk);
    chk("rst_bit3_b", tx[0], 0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_tx", tx[0], 1);
    chk("rst_async_busy", busy[0], 0);
    chk("rst_async_ren", ren[0], 0);
    @(negedge clk);
    chk("rst_held_tx", tx[0], 1);
    rstn = 1'b1;
    @(negedge clk);
    push(0, 8'h81);
    @(negedge clk);
    fetch_seq(0, "post_rst");
    check_frame(0, 16'h0302, 10, "post_rst");
    idle_check(0, 2, "post_rst_after");
    chk("rst_reads", rp[0], 5);

    // i_en dropped during START with three bytes queued
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    @(negedge clk);
    fetch_seq(0, "en");
    en[0] = 1'b0;
    check_frame(0, 16'h0222, 10, "en_frame");
    idle_check(0, 5, "en_off");
    chk("en_reads", rp[0], 6);
    chk("en_left", wp[0] - rp[0], 2);
    en[0] = 1'b1;
    @(negedge clk);
    fetch_seq(0, "en_resume");
    check_frame(0, 16'h0244, 10, "en_f2");
    fetch_seq(0, "en_f3_fetch");
    check_frame(0, 16'h0266, 10, "en_f3");
    idle_check(0, 3, "en_done");
    chk("en_reads_all", rp[0], 8);

    // Even parity, 0xA5 -> parity bit 0, 44-cycle frame
    push(1, 8'hA5);
    @(negedge clk);
    fetch_seq(1, "pev");
    check_frame(1, 16'h054A, 11, "pev");
    idle_check(1, 2, "pev_after");

    // Odd parity, 0xA5 -> parity bit 1
    push(2, 8'hA5);
    @(negedge clk);
    fetch_seq(2, "podd");
    check_frame(2, 16'h074A, 11, "podd");
    idle_check(2, 2, "podd_after");

    // Two stop bits, 0x3C -> stop level held 8 cycles, 44-cycle frame
    push(3, 8'h3C);
    @(negedge clk);
    fetch_seq(3, "stop2");
    check_frame(3, 16'h0678, 11, "stop2");
    idle_check(3, 2, "stop2_after");

    // No reads were ever issued against an empty fifo
    for (int k = 0; k < 4; k++) chk("underflow", underflow[k], 0);
    chk("reads_l1", rp[1], 1);
    chk("reads_l2", rp[2], 1);
    chk("reads_l3", rp[3], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
